// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Registered EX-stage ALU with valid/ready handshake on both
//               sides. Single-cycle logic/arith/shift ops complete in one
//               clock. An iterative shift-add multiply takes WIDTH clocks
//               and is built only when the macro ALU_MUL_EN is defined.
//               Without ALU_MUL_EN, opcode 1110 is reported as illegal.
//               The zero, overflow and illegal flags travel with the result.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             busy
);

    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_XOR = 4'b0011;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;
    localparam logic [3:0] c_OP_SLL = 4'b1000;
    localparam logic [3:0] c_OP_SRL = 4'b1001;
    localparam logic [3:0] c_OP_SRA = 4'b1010;
    localparam logic [3:0] c_OP_NOR = 4'b1100;

    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_overflow;
    logic               r_illegal;
    logic               r_out_valid;

    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_lt;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;
    logic               w_ill;
    logic               w_is_mul;
    logic               w_accept;
    logic               w_idle;
    logic               w_mul_done;
    logic [WIDTH-1:0]   w_mul_res;
    logic               w_mul_ovf;

    assign w_sum   = operand1 + operand2;
    assign w_diff  = operand1 - operand2;
    assign w_shamt = operand2[SHAMT_W-1:0];
    assign w_lt    = $signed(operand1) < $signed(operand2);

    // New work is taken only when idle and the output slot is free or being drained.
    assign in_ready = rst_n && w_idle && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Single-cycle datapath: decode the opcode and produce result plus flags.
    always_comb begin
        w_res    = '0;
        w_ovf    = 1'b0;
        w_ill    = 1'b0;
        w_is_mul = 1'b0;
        case (operation)
            c_OP_AND: w_res = operand1 & operand2;
            c_OP_OR:  w_res = operand1 | operand2;
            c_OP_XOR: w_res = operand1 ^ operand2;
            c_OP_NOR: w_res = ~(operand1 | operand2);
            c_OP_ADD: begin
                w_res = w_sum;
                w_ovf = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != operand1[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res = w_diff;
                w_ovf = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != operand1[WIDTH-1]);
            end
            c_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_lt};
            c_OP_SLL: w_res = operand1 << w_shamt;
            c_OP_SRL: w_res = operand1 >> w_shamt;
            c_OP_SRA: w_res = $signed(operand1) >>> w_shamt;
`ifdef ALU_MUL_EN
            4'b1110:  w_is_mul = 1'b1;
`endif
            default:  w_ill = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int         c_CNT_W   = $clog2(WIDTH) + 1;
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_MUL  = 1'b1;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_start_mul;

    assign w_start_mul = w_accept && w_is_mul;
    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
    assign w_idle      = (r_state == c_ST_IDLE);
    assign w_mul_done  = (r_state == c_ST_MUL) && (r_count == c_CNT_W'(1));
    assign w_mul_res   = w_acc_next[WIDTH-1:0];
    assign w_mul_ovf   = |w_acc_next[2*WIDTH-1:WIDTH];
    assign busy        = (r_state == c_ST_MUL);

    // Multiply sequencer: one conditional add and shift per clock, WIDTH iterations.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_count  <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start_mul) begin
                        r_state  <= c_ST_MUL;
                        r_count  <= c_CNT_W'(WIDTH);
                        r_mcand  <= {{WIDTH{1'b0}}, operand1};
                        r_mplier <= operand2;
                        r_acc    <= '0;
                    end
                end
                c_ST_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_count  <= r_count - c_CNT_W'(1);
                    if (r_count == c_CNT_W'(1)) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end
`else
    assign w_idle     = 1'b1;
    assign w_mul_done = 1'b0;
    assign w_mul_res  = '0;
    assign w_mul_ovf  = 1'b0;
    assign busy       = 1'b0;
`endif

    // Output slot: load on single-cycle accept or multiply completion, clear when drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_result    <= w_res;
            r_zero      <= (w_res == '0);
            r_overflow  <= w_ovf;
            r_illegal   <= w_ill;
            r_out_valid <= 1'b1;
        end else if (w_mul_done) begin
            r_result    <= w_mul_res;
            r_zero      <= (w_mul_res == '0);
            r_overflow  <= w_mul_ovf;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;
    assign illegal   = r_illegal;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Self-checking bench for alu_pipe (WIDTH=32). Directed cases
//               followed by randomized traffic compared against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       operation;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;
    logic             busy;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: the output slot and a pending multiply.
    bit               m_valid;
    logic [WIDTH-1:0] m_res;
    bit               m_zero, m_ovf, m_ill;
    int               m_busy_cnt;
    logic [WIDTH-1:0] m_mul_res;
    bit               m_mul_ovf;
    bit               started;

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .operand1  (operand1),
        .operand2  (operand2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Arithmetic meaning of each opcode, computed with wide signed/unsigned math.
    function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output bit ovf, output bit ill,
                                   output bit mul);
        longint sa, sb, s;
        longint unsigned p;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        r = '0; ovf = 0; ill = 0; mul = 0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd3:  r = a ^ b;
            4'd12: r = ~(a | b);
            4'd2: begin
                s = sa + sb; r = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6: begin
                s = sa - sb; r = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  r = a << sh;
            4'd9:  r = a >> sh;
            4'd10: begin s = sa >>> sh; r = s[31:0]; end
`ifdef ALU_MUL_EN
            4'd14: begin
                p = longint'(a) * longint'(b);
                r = p[31:0]; ovf = (p[63:32] != 0); mul = 1;
            end
`endif
            default: ill = 1;
        endcase
    endfunction

    task automatic drive(input bit v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit ordy);
        in_valid = v; operation = op; operand1 = a; operand2 = b; out_ready = ordy;
    endtask

    // One clock: check handshake outputs, advance the model at the edge, then check the slot.
    task automatic tick();
        bit exp_rdy, ovf, ill, mul;
        logic [31:0] r;
        #1;
        exp_rdy = rst_n && (m_busy_cnt == 0) && (!m_valid || out_ready);
        if (started) begin
            chk("in_ready", in_ready, exp_rdy);
            chk("busy", busy, m_busy_cnt != 0);
        end
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_res = '0; m_zero = 0; m_ovf = 0; m_ill = 0; m_busy_cnt = 0;
        end else if (m_busy_cnt > 0) begin
            m_busy_cnt--;
            if (m_busy_cnt == 0) begin
                m_valid = 1; m_res = m_mul_res; m_zero = (m_mul_res == 0);
                m_ovf = m_mul_ovf; m_ill = 0;
            end
        end else if (in_valid && exp_rdy) begin
            ref_op(operation, operand1, operand2, r, ovf, ill, mul);
            if (mul) begin
                m_busy_cnt = WIDTH; m_mul_res = r; m_mul_ovf = ovf; m_valid = 0;
            end else begin
                m_valid = 1; m_res = r; m_zero = (r == 0); m_ovf = ovf; m_ill = ill;
            end
        end else if (out_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
        started = 1;
        chk("out_valid", out_valid, m_valid);
        chk("result", result, m_res);
        chk("zero", zero, m_zero);
        chk("overflow", overflow, m_ovf);
        chk("illegal", illegal, m_ill);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [3:0] ops [14];
        int n;
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd14, 4'd15, 4'd4, 4'd5};
        started = 0;
        m_valid = 0; m_res = '0; m_zero = 0; m_ovf = 0; m_ill = 0; m_busy_cnt = 0;
        m_mul_res = '0; m_mul_ovf = 0;

        // T1: reset, optionally interrupting a multiply.
        rst_n = 1'b0;
        drive(0, 4'd0, '0, '0, 1);
        tick(); tick();
        rst_n = 1'b1;
        chk("t1_reset_result", result, 32'h0);
        chk("t1_reset_valid", out_valid, 1'b0);
        drive(1, 4'b1110, 32'd3, 32'd5, 1);
        tick();
        drive(0, 4'd0, '0, '0, 1);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick(); tick();
        chk("t1_valid_after_rst", out_valid, 1'b0);
        chk("t1_busy_after_rst", busy, 1'b0);
        chk("t1_result_after_rst", result, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("t1_in_ready", in_ready, 1'b1);

        // T2: signed overflow on ADD.
        drive(1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 1);
        tick();
        chk("t2_result", result, 32'h8000_0000);
        chk("t2_overflow", overflow, 1'b1);
        chk("t2_zero", zero, 1'b0);

        // T3: back-to-back single-cycle ops.
        drive(1, 4'b0110, 32'd5, 32'd5, 1);
        tick();
        chk("t3_sub", result, 32'h0);
        chk("t3_sub_zero", zero, 1'b1);
        drive(1, 4'b1010, 32'h8000_0000, 32'h0000_0124, 1);
        tick();
        chk("t3_sra", result, 32'hF800_0000);
        drive(1, 4'b0111, 32'hFFFF_FFFF, 32'h1, 1);
        tick();
        chk("t3_slt", result, 32'h1);
        chk("t3_valid", out_valid, 1'b1);

        // T4: backpressure holds the slot, release accepts the next op in the same clock.
        drive(1, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 1);
        tick();
        drive(1, 4'b0001, 32'h0000_000F, 32'h0000_00F0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_held", result, 32'h0000_F000);
        end
        chk("t4_stall_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("t4_next", result, 32'h0000_00FF);

`ifdef ALU_MUL_EN
        // T5: iterative multiply latency and flags.
        drive(1, 4'b1110, 32'h0001_0000, 32'h0001_0000, 1);
        tick();
        drive(0, 4'd0, '0, '0, 1);
        n = 0;
        do begin tick(); n++; end while (!out_valid && n < 40);
        chk("t5_latency", n, 32);
        chk("t5_result", result, 32'h0);
        chk("t5_zero", zero, 1'b1);
        chk("t5_overflow", overflow, 1'b1);
        drive(1, 4'b1110, 32'd7, 32'd6, 1);
        tick();
        drive(0, 4'd0, '0, '0, 1);
        n = 0;
        do begin tick(); n++; end while (!out_valid && n < 40);
        chk("t5b_latency", n, 32);
        chk("t5b_result", result, 32'd42);
        chk("t5b_overflow", overflow, 1'b0);
`else
        // Without the multiplier, 1110 is a single-cycle illegal op.
        drive(1, 4'b1110, 32'd7, 32'd6, 1);
        tick();
        chk("t6_mul_illegal", illegal, 1'b1);
        chk("t6_mul_result", result, 32'h0);
        chk("t6_mul_busy", busy, 1'b0);
`endif

        // T6: undefined opcode.
        drive(1, 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1);
        tick();
        chk("t6_result", result, 32'h0);
        chk("t6_illegal", illegal, 1'b1);
        chk("t6_zero", zero, 1'b1);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 7, ops[$urandom_range(0, 13)],
                  pick_operand(), pick_operand(), $urandom_range(0, 3) != 0);
            tick();
        end

        // Drain any pending multiply.
        drive(0, 4'd0, '0, '0, 1);
        for (int i = 0; i < 40; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
